// File: rtl/wram_banked.sv
// Banked CGB work RAM: bank 0 fixed in the lower half, SVBK-selected bank in the upper half,
// with a DMA read port that has priority. Optional power-up clear sweep: WRAM_CLEAR_ON_RESET_EN.
module wram_banked #(
  parameter int DATA_WIDTH      = 8,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int NUM_BANKS       = 8,
  parameter int BANK_SEL_WIDTH  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_cs,
  input  logic                     cpu_we,
  input  logic [BANK_ADDR_WIDTH:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_rvalid,
  output logic                     cpu_wait,
  input  logic                     svbk_we,
  input  logic [DATA_WIDTH-1:0]    svbk_wdata,
  output logic [DATA_WIDTH-1:0]    svbk_rdata,
  input  logic                     dma_req,
  input  logic [BANK_ADDR_WIDTH:0] dma_addr,
  output logic [DATA_WIDTH-1:0]    dma_rdata,
  output logic                     dma_ack,
  output logic                     init_busy
);

  localparam int IDX_W = BANK_SEL_WIDTH + BANK_ADDR_WIDTH;
  localparam int DEPTH = NUM_BANKS << BANK_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [BANK_SEL_WIDTH-1:0] svbk;
  logic                      busy;
  logic                      dma_gnt, cpu_gnt, cpu_wr, cpu_rd;
  logic [IDX_W-1:0]          cpu_idx, dma_idx;
  logic                      mem_we;
  logic [IDX_W-1:0]          mem_widx;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      unused_svbk_bits;

  function automatic logic [IDX_W-1:0] phys(input logic [BANK_ADDR_WIDTH:0] a,
                                             input logic [BANK_SEL_WIDTH-1:0] sel);
    logic [BANK_SEL_WIDTH-1:0] b;
    if (!a[BANK_ADDR_WIDTH])
      b = '0;
    else if (sel == '0)
      b = BANK_SEL_WIDTH'(1);
    else
      b = sel;
    return {b, a[BANK_ADDR_WIDTH-1:0]};
  endfunction

  assign unused_svbk_bits = ^svbk_wdata[DATA_WIDTH-1:BANK_SEL_WIDTH];

  assign cpu_idx = phys(cpu_addr, svbk);
  assign dma_idx = phys(dma_addr, svbk);

  // Nothing is granted while rst is high, so reset never disturbs memory contents.
  assign dma_gnt  = dma_req & ~busy & ~rst;
  assign cpu_gnt  = cpu_cs & ~dma_req & ~busy & ~rst;
  assign cpu_wr   = cpu_gnt & cpu_we;
  assign cpu_rd   = cpu_gnt & ~cpu_we;
  assign cpu_wait = cpu_cs & (dma_req | busy);

  assign svbk_rdata = {{(DATA_WIDTH-BANK_SEL_WIDTH){1'b1}}, svbk};
  assign init_busy  = busy;

`ifdef WRAM_CLEAR_ON_RESET_EN
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]       state;
  logic             clear_pend;
  logic [IDX_W-1:0] clear_cnt;

  // Reset only arms the sweep; it starts on the first edge after rst drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clear_pend <= 1'b1;
      clear_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_pend) begin
            state      <= CLEAR;
            clear_pend <= 1'b0;
            clear_cnt  <= '0;
          end
        end
        CLEAR: begin
          clear_cnt <= clear_cnt + 1'b1;
          // DEPTH is a power of two, so all-ones is the last index.
          if (clear_cnt == '1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CLEAR);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    mem_we    = cpu_wr;
    mem_widx  = cpu_idx;
    mem_wdata = cpu_wdata;
`ifdef WRAM_CLEAR_ON_RESET_EN
    if (busy) begin
      mem_we    = 1'b1;
      mem_widx  = clear_cnt;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
      dma_rdata  <= '0;
      dma_ack    <= 1'b0;
      svbk       <= '0;
    end else begin
      cpu_rvalid <= cpu_rd;
      dma_ack    <= dma_gnt;
      if (cpu_rd)  cpu_rdata <= mem[cpu_idx];
      if (dma_gnt) dma_rdata <= mem[dma_idx];
      if (svbk_we) svbk <= svbk_wdata[BANK_SEL_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_wram_banked.sv
// Self-checking bench for wram_banked: directed bank/arbiter cases plus random traffic
// against a flat-array reference model.
`timescale 1ns/1ps
module tb_wram_banked;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cs, cpu_we, svbk_we, dma_req;
  logic [12:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, svbk_wdata;
  logic [7:0]  cpu_rdata, svbk_rdata, dma_rdata;
  logic        cpu_rvalid, cpu_wait, dma_ack, init_busy;

  always #5 clk = ~clk;

  wram_banked #(
    .DATA_WIDTH(8), .BANK_ADDR_WIDTH(12), .NUM_BANKS(8), .BANK_SEL_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_wait(cpu_wait),
    .svbk_we(svbk_we), .svbk_wdata(svbk_wdata), .svbk_rdata(svbk_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .init_busy(init_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: flat 32 KiB array, bank selector and expected read registers.
  logic [7:0] mdata  [32768];
  bit         mknown [32768];
  int         svbk_m;
  logic [7:0] exp_cd, exp_dd;
  bit         cd_known, dd_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int phys(input logic [12:0] a, input int sv);
    if (!a[12]) return int'(a[11:0]);
    return ((sv == 0) ? 1 : sv) * 4096 + int'(a[11:0]);
  endfunction

  task automatic idle_inputs();
    cpu_cs = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    svbk_we = 0; svbk_wdata = '0; dma_req = 0; dma_addr = '0;
  endtask

  // One clock of stimulus: apply, check the combinational stall, advance, check registered outputs.
  task automatic cycle(input bit cs, input bit we, input logic [12:0] a, input logic [7:0] wd,
                       input bit svwe, input logic [7:0] svwd, input bit dreq, input logic [12:0] da);
    bit exp_rv, exp_ack;
    int p;
    cpu_cs = cs; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    svbk_we = svwe; svbk_wdata = svwd; dma_req = dreq; dma_addr = da;
    #1;
    check("cpu_wait", cpu_wait, cs & dreq);
    exp_rv = 0; exp_ack = 0;
    if (dreq) begin
      exp_ack = 1;
      p = phys(da, svbk_m);
      dd_known = mknown[p];
      exp_dd   = mdata[p];
    end else if (cs && we) begin
      p = phys(a, svbk_m);
      mdata[p]  = wd;
      mknown[p] = 1;
    end else if (cs) begin
      exp_rv = 1;
      p = phys(a, svbk_m);
      cd_known = mknown[p];
      exp_cd   = mdata[p];
    end
    if (svwe) svbk_m = int'(svwd[2:0]);
    @(posedge clk); #1;
    idle_inputs();
    check("cpu_rvalid", cpu_rvalid, exp_rv);
    check("dma_ack", dma_ack, exp_ack);
    if (cd_known) check("cpu_rdata", cpu_rdata, exp_cd);
    if (dd_known) check("dma_rdata", dma_rdata, exp_dd);
    check("svbk_rdata", svbk_rdata, 8'hF8 | 8'(svbk_m));
  endtask

  task automatic wr(input logic [12:0] a, input logic [7:0] d);
    cycle(1, 1, a, d, 0, 8'h00, 0, 13'h0);
  endtask

  task automatic rd(input logic [12:0] a);
    cycle(1, 0, a, 8'h00, 0, 8'h00, 0, 13'h0);
  endtask

  task automatic set_svbk(input logic [7:0] v);
    cycle(0, 0, 13'h0, 8'h00, 1, v, 0, 13'h0);
  endtask

  // Reset with a write attempt held on the bus; the write must not land.
  task automatic do_reset();
    int n;
    idle_inputs();
    rst = 1;
    cpu_cs = 1; cpu_we = 1; cpu_addr = 13'h0003; cpu_wdata = 8'hEE;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_cpu_rdata", cpu_rdata, 8'h00);
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_dma_rdata", dma_rdata, 8'h00);
    check("rst_dma_ack", dma_ack, 1'b0);
    check("rst_svbk", svbk_rdata, 8'hF8);
    check("rst_init_busy", init_busy, 1'b0);
    idle_inputs();
    rst = 0;
    svbk_m = 0; exp_cd = 0; exp_dd = 0; cd_known = 1; dd_known = 1;
`ifdef WRAM_CLEAR_ON_RESET_EN
    n = 0;
    for (int i = 0; i < 40000; i++) begin
      @(posedge clk); #1;
      if (i == 6) begin
        check("clear_no_ack", dma_ack, 1'b0);
        check("clear_no_rvalid", cpu_rvalid, 1'b0);
        idle_inputs();
      end
      if (init_busy) n++;
      else break;
      if (i == 5) begin
        cpu_cs = 1; cpu_we = 1; cpu_addr = 13'h0007; cpu_wdata = 8'h77;
        dma_req = 1; dma_addr = 13'h0007;
        #1;
        check("clear_cpu_wait", cpu_wait, 1'b1);
      end
    end
    check("clear_cycles", n, 32768);
    for (int i = 0; i < 32768; i++) begin mdata[i] = 8'h00; mknown[i] = 1; end
`else
    n = 0;
    @(posedge clk); #1;
    check("init_busy_tied", init_busy, n);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32768; i++) begin mdata[i] = 8'h00; mknown[i] = 0; end
    idle_inputs();
    rst = 1;
    do_reset();

`ifdef WRAM_CLEAR_ON_RESET_EN
    rd(13'h1ABC);
    check("t6_zero_upper", cpu_rdata, 8'h00);
    cycle(0, 0, 13'h0, 8'h00, 0, 8'h00, 1, 13'h0FFF);
    check("t6_zero_dma", dma_rdata, 8'h00);
`endif

    // T1
    wr(13'h0005, 8'hA5);
    rd(13'h0005);
    check("t1_rdata", cpu_rdata, 8'hA5);

    // T2: svbk 0 aliases bank 1
    set_svbk(8'h00);
    wr(13'h1010, 8'h11);
    set_svbk(8'h02);
    wr(13'h1010, 8'h22);
    set_svbk(8'h01);
    rd(13'h1010);
    check("t2_alias", cpu_rdata, 8'h11);

    // T3: same-cycle write uses old bank (2)
    set_svbk(8'h02);
    cycle(1, 1, 13'h1000, 8'h33, 1, 8'h05, 0, 13'h0);
    check("t3_svbk_rdata", svbk_rdata, 8'hFD);
    wr(13'h1000, 8'h55);
    set_svbk(8'h02);
    rd(13'h1000);
    check("t3_old_bank", cpu_rdata, 8'h33);
    set_svbk(8'h05);
    rd(13'h1000);
    check("t3_new_bank", cpu_rdata, 8'h55);

    // T4: DMA wins, CPU retries next cycle
    wr(13'h0100, 8'h6C);
    cycle(1, 0, 13'h0100, 8'h00, 0, 8'h00, 1, 13'h0100);
    check("t4_dma_data", dma_rdata, 8'h6C);
    rd(13'h0100);
    check("t4_cpu_data", cpu_rdata, 8'h6C);

    // T5: 160-byte DMA burst, one ack per cycle
    for (int i = 0; i < 160; i++) wr(13'h1200 + 13'(i), 8'($urandom));
    for (int i = 0; i < 160; i++) cycle(0, 0, 13'h0, 8'h00, 0, 8'h00, 1, 13'h1200 + 13'(i));

    // Random traffic over a small address pool so reads hit written data
    for (int i = 0; i < 600; i++) begin
      logic [12:0] a, da;
      a  = 13'($urandom_range(0, 1) << 12) | 13'($urandom_range(0, 15));
      da = 13'($urandom_range(0, 1) << 12) | 13'($urandom_range(0, 15));
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a, 8'($urandom),
            $urandom_range(0, 4) == 0, 8'($urandom), $urandom_range(0, 3) == 0, da);
    end

    // Mid-operation reset: svbk returns to 0, contents survive (or are swept to 0)
    set_svbk(8'h03);
    wr(13'h0003, 8'h5A);
    cycle(1, 0, 13'h0003, 8'h00, 0, 8'h00, 0, 13'h0);
    do_reset();
    rd(13'h0003);
`ifdef WRAM_CLEAR_ON_RESET_EN
    check("midrst_contents", cpu_rdata, 8'h00);
`else
    check("midrst_contents", cpu_rdata, 8'h5A);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
